aes256_key_schedule: RTL and testbench
======================================

# aes256_key_schedule

Sequential AES-256 key expansion (FIPS-197) for the encrypt_256 datapath.
- Takes a 256-bit cipher key and produces round keys 1..14 as 128-bit buses, which feed the round AddRoundKey stages.
- Round key 0 is the first 128 bits of the key; the datapath uses it directly.
- Generates one 32-bit schedule word per clock, using an internal S-box and Rcon table.

## Interface
Parameters:
- NK, 8, key length in 32-bit words (fixed; other values unsupported)
- NB, 4, state columns
- NR, 14, number of rounds

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  start request; sampled only in IDLE or DONE
- CurrentKey  in  8 x 32 bytes  cipher key; CurrentKey[0] is the first key byte
- key1 … key14  out  128 each  round keys; keyN[127:96] = w[4N], keyN[31:0] = w[4N+3]
- ready  out  1  high when all round keys are valid and stable

## Operation
- Word packing: w[j] = {CurrentKey[4j], CurrentKey[4j+1], CurrentKey[4j+2], CurrentKey[4j+3]} for j = 0..7. The first byte is the most significant.
- Recurrence for i = 8..59, with t = w[i-1]:
  - if i mod 8 = 0: t = SubWord(RotWord(t)) ^ {Rcon[i/8], 24'h0}
  - if i mod 8 = 4: t = SubWord(t)
  - then w[i] = w[i-8] ^ t
- RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
- Storage: an 8-word sliding window holding w[i-8..i-1], plus the 14 round-key registers.
- States and transitions:
  - IDLE, en=1: capture CurrentKey into the window, write key1 = {w4..w7}, go to BUSY.
  - BUSY: compute one word per cycle and write it into its keyN slot. After w[59], go to DONE.
  - DONE, en=1: restart exactly as from IDLE. ready falls on that edge.
- en is ignored in BUSY, whether it is held or re-pulsed.
- CurrentKey is sampled only at the start edge. Changes during BUSY have no effect.
- During BUSY, keyN registers update word by word. Their values are defined only once complete.
- Pipeline: none. One expansion at a time.

## Timing
- Reset: state IDLE, ready = 0, key1..key14 = 0, window = 0. Takes effect immediately, no clock needed.
- Start edge S: key1 is valid after S.
- w[i] is written at edge S+(i-7). So keyN (N ≥ 2) is complete after edge S+4N-4, and key14 after S+52.
- ready rises after edge S+52 (52 cycles of latency). It stays high until reset or a restart from DONE.
- Reset asserted mid-BUSY: abort, clear everything, return to IDLE. The next run needs a fresh en.
- rst deasserted with en already high: the start happens on the first clock edge after deassertion.

## Configuration
- AES256_KEYEXP_KEY0_EN defined: adds output key0 (128 bits).
  - Registered with {w0..w3} at the start edge.
  - Reset value 0.
  - Lets the datapath take all 15 round keys from this block.
- AES256_KEYEXP_KEY0_EN undefined: no key0 port. Behaviour of all other outputs is identical.

## Test plan
- Reset: hold rst=0, pulse en -> ready=0, all keys 0, state stays IDLE. Release rst, en=1 for one cycle -> ready rises exactly 52 cycles later.
- FIPS key 000102…1f -> key1 = 101112131415161718191a1b1c1d1e1f, key2 = a573c29fa176c498a97fce93a572c09c, key14 = 24fc79ccbf0979e9371ac23c6d68de36.
- FIPS A.3 key 603deb1015ca71be2b73aef0857d7781 1f352c073b6108d72d9810a30914dff4 -> w8 = 9ba35411, key14 = fe4890d1e6188d0b046df344706c631e.
- Change CurrentKey and toggle en during BUSY -> results still equal the first key's schedule, and ready still occurs at S+52.
- Assert rst at S+20 -> outputs clear immediately. A restart with a new key gives the correct schedule after 52 cycles.
- In DONE, apply en with a new key -> ready drops the next cycle, new keys valid 52 cycles later. With AES256_KEYEXP_KEY0_EN, key0 equals the first 16 key bytes.

Source files
------------

// File: rtl/aes256_key_schedule.sv
// AES-256 key expansion: one 32-bit schedule word per clock into 14 round-key registers.
// Optional AES256_KEYEXP_KEY0_EN adds a registered key0 output holding the first 128 key bits.
module aes256_key_schedule #(
  parameter int NK = 8,
  parameter int NB = 4,
  parameter int NR = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [0:4*NK-1][7:0]  CurrentKey,
`ifdef AES256_KEYEXP_KEY0_EN
  output logic [127:0]          key0,
`endif
  output logic [127:0]          key1,
  output logic [127:0]          key2,
  output logic [127:0]          key3,
  output logic [127:0]          key4,
  output logic [127:0]          key5,
  output logic [127:0]          key6,
  output logic [127:0]          key7,
  output logic [127:0]          key8,
  output logic [127:0]          key9,
  output logic [127:0]          key10,
  output logic [127:0]          key11,
  output logic [127:0]          key12,
  output logic [127:0]          key13,
  output logic [127:0]          key14,
  output logic                  ready
);

  localparam int LAST = NB * (NR + 1) - 1;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] f_subword(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] f_rcon(input logic [2:0] r);
    case (r)
      3'd1:    return 8'h01;
      3'd2:    return 8'h02;
      3'd3:    return 8'h04;
      3'd4:    return 8'h08;
      3'd5:    return 8'h10;
      3'd6:    return 8'h20;
      3'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic                      w_start;
  logic [NK-1:0][31:0]       w_kw;
  logic [NK-1:0][31:0]       r_win;   // r_win[0] = w[i-8], r_win[NK-1] = w[i-1]
  logic [NR:1][0:NB-1][31:0] r_rk;
  logic [5:0]                r_idx;
  logic [31:0]               w_prev, w_rot, w_t, w_new;
  logic [7:0]                w_rcon;
`ifdef AES256_KEYEXP_KEY0_EN
  logic [127:0]              r_key0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (en) begin
        w_start     = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: if (r_idx == 6'(LAST)) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // First key byte is the most significant byte of word 0.
  always_comb begin
    for (int j = 0; j < NK; j++)
      w_kw[j] = {CurrentKey[4*j], CurrentKey[4*j+1], CurrentKey[4*j+2], CurrentKey[4*j+3]};
  end

  always_comb begin
    w_prev = r_win[NK-1];
    w_rot  = {w_prev[23:0], w_prev[31:24]};
    w_rcon = f_rcon(r_idx[5:3]);
    case (r_idx[2:0])
      3'd0:    w_t = f_subword(w_rot) ^ {w_rcon, 24'h0};
      3'd4:    w_t = f_subword(w_prev);
      default: w_t = w_prev;
    endcase
    w_new = r_win[0] ^ w_t;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win  <= '0;
      r_rk   <= '0;
      r_idx  <= '0;
`ifdef AES256_KEYEXP_KEY0_EN
      r_key0 <= '0;
`endif
    end else if (w_start) begin
      r_win   <= w_kw;
      r_rk[1] <= {w_kw[4], w_kw[5], w_kw[6], w_kw[7]};
      r_idx   <= 6'(NK);
`ifdef AES256_KEYEXP_KEY0_EN
      r_key0  <= {w_kw[0], w_kw[1], w_kw[2], w_kw[3]};
`endif
    end else if (r_state == S_BUSY) begin
      // w[i] lands in round key i/4, word i%4 (word 0 is the MS word).
      r_win                       <= {w_new, r_win[NK-1:1]};
      r_rk[r_idx[5:2]][r_idx[1:0]] <= w_new;
      r_idx                       <= r_idx + 6'd1;
    end
  end

`ifdef AES256_KEYEXP_KEY0_EN
  assign key0 = r_key0;
`endif
  assign key1  = r_rk[1];
  assign key2  = r_rk[2];
  assign key3  = r_rk[3];
  assign key4  = r_rk[4];
  assign key5  = r_rk[5];
  assign key6  = r_rk[6];
  assign key7  = r_rk[7];
  assign key8  = r_rk[8];
  assign key9  = r_rk[9];
  assign key10 = r_rk[10];
  assign key11 = r_rk[11];
  assign key12 = r_rk[12];
  assign key13 = r_rk[13];
  assign key14 = r_rk[14];
  assign ready = (r_state == S_DONE);

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Scoreboarded bench for aes256_key_schedule: reference expansion from GF(2^8) arithmetic.
module tb_aes256_key_schedule;
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic [0:31][7:0] CurrentKey = '0;
  logic [127:0]     key1, key2, key3, key4, key5, key6, key7, key8, key9, key10,
                    key11, key12, key13, key14;
`ifdef AES256_KEYEXP_KEY0_EN
  logic [127:0]     key0;
`endif
  logic             ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [14:0][127:0] k;
    int                 start;
  } exp_t;
  exp_t q[$];

  logic [7:0]   sb [256];
  logic [127:0] dk [1:14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes256_key_schedule dut (
    .clk(clk), .rst(rst), .en(en), .CurrentKey(CurrentKey),
`ifdef AES256_KEYEXP_KEY0_EN
    .key0(key0),
`endif
    .key1(key1), .key2(key2), .key3(key3), .key4(key4), .key5(key5), .key6(key6),
    .key7(key7), .key8(key8), .key9(key9), .key10(key10), .key11(key11),
    .key12(key12), .key13(key13), .key14(key14), .ready(ready)
  );

  assign dk[1]  = key1;   assign dk[2]  = key2;   assign dk[3]  = key3;
  assign dk[4]  = key4;   assign dk[5]  = key5;   assign dk[6]  = key6;
  assign dk[7]  = key7;   assign dk[8]  = key8;   assign dk[9]  = key9;
  assign dk[10] = key10;  assign dk[11] = key11;  assign dk[12] = key12;
  assign dk[13] = key13;  assign dk[14] = key14;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [14:0][127:0] model(input logic [255:0] key);
    logic [31:0]        w [60];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [14:0][127:0] r;
    for (int j = 0; j < 8; j++) w[j] = key[255-32*j -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int n = 0; n < 15; n++) r[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: each rising ready retires one expected schedule.
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ready && !prev_rdy) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready cyc=%0d", cyc);
      end else begin
        e = q.pop_front();
        chk("latency", 128'(cyc - e.start), 128'd52);
        for (int n = 1; n <= 14; n++) chk($sformatf("key%0d", n), dk[n], e.k[n]);
`ifdef AES256_KEYEXP_KEY0_EN
        chk("key0", key0, e.k[0]);
`endif
      end
    end
    prev_rdy <= ready;
  end

  // Called at a falling edge; the next rising edge is the start edge.
  task automatic start(input logic [255:0] key);
    exp_t e;
    CurrentKey = key;
    en         = 1'b1;
    e.k        = model(key);
    e.start    = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    en = 1'b0;
    chk("ready_low_after_start", 128'(ready), 128'd0);
    chk("key1_after_start", dk[1], e.k[1]);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (q.size() != 0 && c < 80) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL ready_timeout pending=%0d", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    build_sbox();

    // Reset held: en pulses must not start anything.
    repeat (2) @(negedge clk);
    en         = 1'b1;
    CurrentKey = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'd0);
    chk("rst_key1", key1, 128'd0);
    chk("rst_key14", key14, 128'd0);

    // Release reset with en already high.
    rst = 1'b1;
    start(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    wait_done();
    chk("fips_key1", key1, 128'h101112131415161718191a1b1c1d1e1f);
    chk("fips_key2", key2, 128'ha573c29fa176c498a97fce93a572c09c);
    chk("fips_key14", key14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Restart from DONE with the FIPS A.3 key.
    start(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    wait_done();
    chk("a3_w8", 128'(key2[127:96]), 128'h9ba35411);
    chk("a3_key14", key14, 128'hfe4890d1e6188d0b046df344706c631e);

    // en noise and key changes during BUSY are ignored.
    start(rand256());
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      en         = 1'($urandom_range(0, 1));
      CurrentKey = rand256();
    end
    en = 1'b0;
    wait_done();

    // Abort mid-expansion, then a fresh run.
    start(rand256());
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'd0);
    for (int n = 1; n <= 14; n++) chk($sformatf("abort_key%0d", n), dk[n], 128'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_abort", 128'(ready), 128'd0);
    start(rand256());
    wait_done();

    // Back-to-back restarts from DONE with random keys.
    for (int r = 0; r < 4; r++) begin
      start(rand256());
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
